// File: rtl/result_tx_if.sv
// result_tx_if: value-in and byte-out handshake bundle for result_tx_formatter.
//
// Handshake semantics, for both channels (val_* and tx_*):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   A source that raises valid keeps it high, with its payload held stable,
//   until that transfer happens. A sink may raise or lower ready at any time.
//   Reset is the only thing that can withdraw a pending valid.
interface result_tx_if #(
  parameter int VAL_W = 32
);
  logic [VAL_W-1:0] val_in;
  logic             val_last;
  logic             val_valid;
  logic             val_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             line_done;

  // Environment side: value producer plus the UART TX byte sink.
  modport master (
    output val_in, val_last, val_valid, tx_ready,
    input  val_ready, tx_data, tx_valid, line_done
  );

  // Formatter side.
  modport slave (
    input  val_in, val_last, val_valid, tx_ready,
    output val_ready, tx_data, tx_valid, line_done
  );
endinterface

// File: rtl/result_tx_formatter.sv
// result_tx_formatter: turns unsigned result values into ASCII decimal text
// and streams it byte by byte to the UART TX. Values on one line are
// separated by ',' and the line ends with LF after the value flagged last.
// Optional feature: define CRLF_EN to end lines with CR LF instead of LF.
module result_tx_formatter #(
  parameter int VAL_W      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic            clk,
  input  logic            reset,
  result_tx_if.slave      bus,
  output logic [2:0]      state_dbg
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_EMIT = 3'd2,
    S_SEP  = 3'd3,
    S_EOL  = 3'd4
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;
  logic [3:0]       digit_buf [MAX_DIGITS];
`ifdef CRLF_EN
  logic             eol_lf_r;   // 0: CR is on the wire, 1: LF is on the wire
`endif

  logic [VAL_W-1:0] q_div;
  logic [3:0]       q_mod;
  logic [CNT_W-1:0] cnt_m2;

  // Divide-by-ten step of the conversion, and the index of the digit that
  // follows the one currently on the wire.
  always_comb begin
    q_div  = q_r / VAL_W'(10);
    q_mod  = 4'(q_r % VAL_W'(10));
    cnt_m2 = cnt_r - CNT_W'(2);
  end

  // Main FSM. Digits are stored least significant first and emitted from the
  // top of the buffer down, so leading zeros never exist. tx_data/tx_valid
  // are loaded one step ahead so they come straight from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      q_r        <= '0;
      cnt_r      <= '0;
      last_r     <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
`ifdef CRLF_EN
      eol_lf_r   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.val_valid) begin
            q_r    <= bus.val_in;
            last_r <= bus.val_last;
            cnt_r  <= '0;
            state  <= S_CONV;
          end
        end

        S_CONV: begin
          digit_buf[cnt_r] <= q_mod;
          q_r              <= q_div;
          cnt_r            <= cnt_r + CNT_W'(1);
          if (q_div == '0) begin
            // The digit produced this cycle is the most significant one.
            state      <= S_EMIT;
            tx_valid_r <= 1'b1;
            tx_data_r  <= {4'h3, q_mod};
          end
        end

        S_EMIT: begin
          if (bus.tx_ready) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              if (last_r) begin
                state <= S_EOL;
`ifdef CRLF_EN
                tx_data_r <= 8'h0D;
                eol_lf_r  <= 1'b0;
`else
                tx_data_r <= 8'h0A;
`endif
              end else begin
                state     <= S_SEP;
                tx_data_r <= 8'h2C;
              end
            end else begin
              tx_data_r <= {4'h3, digit_buf[cnt_m2]};
            end
          end
        end

        S_SEP: begin
          if (bus.tx_ready) begin
            state      <= S_IDLE;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
          end
        end

        S_EOL: begin
          if (bus.tx_ready) begin
`ifdef CRLF_EN
            if (!eol_lf_r) begin
              eol_lf_r  <= 1'b1;
              tx_data_r <= 8'h0A;
            end else begin
              eol_lf_r   <= 1'b0;
              state      <= S_IDLE;
              tx_valid_r <= 1'b0;
              tx_data_r  <= 8'h00;
            end
`else
            state      <= S_IDLE;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
`endif
          end
        end

        default: begin
          state      <= S_IDLE;
          tx_valid_r <= 1'b0;
          tx_data_r  <= 8'h00;
        end
      endcase
    end
  end

  // Output decode: everything is forced quiet while reset is held low; no
  // path from tx_ready reaches tx_valid or tx_data.
  always_comb begin
    bus.val_ready = reset && (state == S_IDLE);
    bus.tx_valid  = reset && tx_valid_r;
    bus.tx_data   = reset ? tx_data_r : 8'h00;
`ifdef CRLF_EN
    bus.line_done = reset && (state == S_EOL) && eol_lf_r && bus.tx_ready;
`else
    bus.line_done = reset && (state == S_EOL) && bus.tx_ready;
`endif
    state_dbg     = state;
  end

endmodule

// File: tb/tb_result_tx_formatter.sv
// tb_result_tx_formatter: directed vectors for result_tx_formatter with an
// expected-byte queue checked by an independent output monitor.
module tb_result_tx_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] val_in = '0;
  logic        val_last = 1'b0;
  logic        val_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        rand_ready = 1'b0;
  logic [2:0]  state_dbg;

  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_count = 0;
  int          ld_cnt = 0;
  int          exp_lines = 0;

  logic        stall_pend = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  logic        ld_pend = 1'b0;
  logic [7:0]  mon_e;

  result_tx_if #(.VAL_W(32)) bus ();

  assign bus.val_in    = val_in;
  assign bus.val_last  = val_last;
  assign bus.val_valid = val_valid;
  assign bus.tx_ready  = tx_ready;

  result_tx_formatter #(.VAL_W(32), .MAX_DIGITS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // UART sink: ready either held high or toggled randomly, changed after edges.
  always @(posedge clk) begin
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: queue the expected text for one value, then hand the value over.
  task automatic send_value(input logic [31:0] v, input logic last);
    string s;
    bit    ok;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (last) begin
`ifdef CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
      exp_lines++;
    end else begin
      exp_q.push_back(8'h2C);
    end
    @(posedge clk); #1;
    val_in    = v;
    val_last  = last;
    val_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.val_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    val_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the expected queue on every byte handshake.
  always @(negedge clk) begin
    if (!reset) begin
      stall_pend = 1'b0;
      ld_pend    = 1'b0;
    end else begin
      if (ld_pend) begin
        check("ready_after_eol", 32'(bus.val_ready), 32'd1);
        ld_pend = 1'b0;
      end
      if (stall_pend) begin
        check("stall_valid_held", 32'(bus.tx_valid), 32'd1);
        check("stall_data_held", 32'(bus.tx_data), 32'(stall_data));
      end
      if (bus.tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(mon_e));
          check("line_done_on_lf", 32'(bus.line_done), 32'(mon_e == 8'h0A));
        end
        hs_count++;
        if (bus.line_done) begin
          ld_cnt++;
          ld_pend = 1'b1;
        end
      end else if (bus.line_done) begin
        check("line_done_no_hs", 32'(bus.line_done), 32'd0);
      end
      stall_pend = bus.tx_valid && !tx_ready;
      stall_data = bus.tx_data;
    end
  end

  initial begin
    int lat;
    int base;
    bit ok;

    // Reset phase
    repeat (3) begin
      @(negedge clk);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_val_ready", 32'(bus.val_ready), 32'd0);
      check("rst_line_done", 32'(bus.line_done), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_val_ready", 32'(bus.val_ready), 32'd1);
    check("idle_state", 32'(state_dbg), 32'd0);
    check("idle_tx_data", 32'(bus.tx_data), 32'd0);

    // Zero prints one digit
    send_value(32'd0, 1'b1);
    drain("drain_zero");
    check("lines_after_zero", 32'(ld_cnt), 32'd1);

    // Multi-value line "7,12,28\n"
    send_value(32'd7, 1'b0);
    send_value(32'd12, 1'b0);
    send_value(32'd28, 1'b1);
    drain("drain_list");

    // Full-width value and first-byte latency
    send_value(32'hFFFF_FFFF, 1'b1);
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.tx_valid) begin
        lat = k;
        break;
      end
    end
    check("max_latency", 32'(lat), 32'd11);
    drain("drain_max");

    // Random back-pressure
    rand_ready = 1'b1;
    send_value(32'd305, 1'b1);
    drain("drain_stall");
    send_value(32'd1000, 1'b0);
    send_value(32'd64, 1'b1);
    drain("drain_stall2");
    rand_ready = 1'b0;

    // Reset in the middle of a line
    base = hs_count;
    send_value(32'd12345, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (hs_count >= base + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reset_wait", 32'(ok), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_lines--;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("mid_rst_line_done", 32'(bus.line_done), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("post_rst_val_ready", 32'(bus.val_ready), 32'd1);
    send_value(32'd9, 1'b1);
    drain("drain_after_reset");

    check("line_done_total", 32'(ld_cnt), 32'(exp_lines));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_tx_formatter.md
# result_tx_formatter

Converts unsigned sequence results into ASCII decimal text and streams it byte-by-byte to the UART transmitter. It is the outbound counterpart of the command parser: the parser consumes lines such as "P,12\n", and this block produces reply lines such as "1,1,1,2,2,3\n". It sits between the sequence-generator FSM (value source) and the UART TX byte interface (sink).

## Interface
- VAL_W, 32, width of input value (unsigned)
- MAX_DIGITS, 10, digit buffer depth; must be ≥ decimal digits of 2^VAL_W−1
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- val_in  input  VAL_W  result value to print
- val_last  input  1  value is last of the line (terminate with EOL instead of ',')
- val_valid  input  1  val_in/val_last valid
- val_ready  output  1  block can accept a value
- tx_data  output  8  ASCII byte to UART TX
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART TX accepts byte this cycle
- line_done  output  1  one-cycle pulse when the final EOL byte is accepted

## Operation
- States: S_IDLE, S_CONV, S_EMIT, S_SEP, S_EOL.
- S_IDLE: val_ready=1. On val_valid&&val_ready: latch val_in into quotient q, latch val_last, clear digit count cnt → S_CONV. val_valid outside S_IDLE is ignored (no accept).
- S_CONV: each cycle buf[cnt] <= q%10, q <= q/10, cnt <= cnt+1; when q/10==0 (this cycle) → S_EMIT. Value 0 produces exactly one digit "0". Leading zeros never emitted.
- S_EMIT: tx_valid=1, tx_data = 0x30 + buf[cnt−1]. On tx_ready: cnt <= cnt−1; if cnt==1 → S_SEP if !last_r, S_EOL if last_r.
- S_SEP: tx_data=0x2C (','); on tx_ready → S_IDLE.
- S_EOL: tx_data=0x0A; on tx_ready → S_IDLE, line_done=1 that cycle.
- Digit buffer: MAX_DIGITS × 4 bit; cnt width $clog2(MAX_DIGITS+1); q width VAL_W.
- Outputs when reset low or not in an emitting state: tx_valid=0, tx_data=0x00, val_ready=0 (during reset), line_done=0.

## Timing
- Reset: synchronous; at the first rising edge with reset=0 state → S_IDLE, cnt=0, buffer contents don't-care. val_ready is gated low while reset=0 and rises combinationally once reset=1.
- Reset mid-operation: partial line discarded; no further bytes; tx_valid low from the edge on.
- Accept at edge T; conversion occupies D cycles (D = digit count); tx_valid first high in cycle T+D+1.
- tx_valid/tx_data decoded from registers only; no combinational path tx_ready→tx_valid/tx_data.
- While tx_valid&&!tx_ready, tx_data held stable; tx_valid never drops without a handshake (except reset).
- One byte per cycle max when tx_ready held high: value of D digits + separator occupies D (conv) + D+1 (emit) cycles, then 1 cycle in S_IDLE before the next accept.
- line_done coincides with the handshake cycle of the final EOL byte.

## Configuration
- CRLF_EN: when defined, S_EOL emits 0x0D then 0x0A (two handshakes, sub-flag tracks which); line_done pulses on the 0x0A handshake. When undefined, EOL is the single byte 0x0A.

## Test plan
- val_in=0, val_last=1, tx_ready=1 → bytes 0x30, 0x0A; line_done pulses once with 0x0A; val_ready back high next cycle.
- Values 7(last 0), 12(last 0), 28(last 1) → byte stream "7,12,28\n" (0x37 0x2C 0x31 0x32 0x2C 0x32 0x38 0x0A).
- val_in=4294967295, last=1 → "4294967295\n"; first tx_valid exactly 11 cycles after accept edge.
- val_in=305, last=1 with tx_ready randomly deasserted → tx_data stable while stalled; stream "305\n" unchanged; no dropped/duplicated bytes.
- val_in=12345 last=1, reset=0 after 2 bytes accepted → tx_valid low from reset edge; after release send 9 last=1 → "9\n" only.
- CRLF_EN defined, val_in=5 last=1 → 0x35, 0x0D, 0x0A; line_done on 0x0A only.
